us_bridge_driver: RTL and testbench
===================================

US_BRIDGE_DRIVER -- requirements
Module: us_bridge_driver

Interface
REQ-001 SHALL have parameter PERIOD, default 675, meaning clk cycles per carrier period (40 kHz at 27 MHz).
REQ-002 SHALL have parameter DEAD, default 8, meaning minimum clk cycles between one leg going low and the other going high.
REQ-003 SHALL have parameter DUTY_W, default 10, meaning duty sample width.
REQ-004 Port clk  input  1  is the system clock; all logic is on its rising edge.
REQ-005 Port rst_n  input  1  is the reset: asynchronous and active-low.
REQ-006 Port enable  input  1  requests bridge operation.
REQ-007 Port duty_data  input  DUTY_W  is the per-period on-time in clk cycles.
REQ-008 Port duty_valid  input  1  qualifies duty_data.
REQ-009 Port duty_ready  output  1  means the holding register is empty.
REQ-010 Port ch_a  output  1  is the positive-leg gate drive.
REQ-011 Port ch_b  output  1  is the negative-leg gate drive.
REQ-012 Port period_start  output  1  is a one-cycle pulse at phase 0 of each running period.
REQ-013 Port underrun  output  1  is a one-cycle pulse when a period starts with no fresh sample.
REQ-014 Port busy  output  1  is high in the RUN and DRAIN states.

Function
REQ-015 SHALL derive HALF = PERIOD/2 (floor) and DMAX = HALF - DEAD, both as package constants.
REQ-016 SHALL run a phase counter 0..PERIOD-1 that wraps to 0; it advances only in RUN and DRAIN and is held at 0 in IDLE.
REQ-017 SHALL accept a sample on any cycle with duty_valid && duty_ready; duty_ready SHALL fall on the next cycle.
REQ-018 SHALL transfer the holding register to the active duty register when phase == PERIOD-1; duty_ready SHALL rise on the next cycle.
REQ-019 SHALL allow an accept and a transfer in the same cycle: the old value goes to active, the new value is held, and duty_ready stays low.
REQ-020 On a transfer with the holding register empty, SHALL keep the previous active duty and pulse underrun together with the next period_start.
REQ-021 SHALL saturate the active duty to DMAX; it SHALL NOT wrap.
REQ-022 SHALL drive ch_a = 1 when phase < active duty.
REQ-023 SHALL drive ch_b = 1 when HALF <= phase < HALF + active duty.
REQ-024 Both legs SHALL be 0 at all other times; ch_a && ch_b SHALL never be 1, including across period wrap.
REQ-025 SHALL implement the FSM IDLE -> RUN when enable = 1, taking effect on the next phase 0.
REQ-026 SHALL implement RUN -> DRAIN when enable falls.
REQ-027 DRAIN SHALL finish the current period, then go to IDLE at phase PERIOD-1.
REQ-028 In DRAIN, SHALL go back to RUN if enable returns high before the period ends.
REQ-029 In IDLE, ch_a and ch_b SHALL be 0 and period_start SHALL be 0; duty_ready SHALL still follow REQ-017/018, so a sample can be preloaded.
REQ-030 The first RUN period SHALL use the preloaded sample if one is present; otherwise it SHALL use active duty 0 and pulse underrun.
REQ-031 ch_a and ch_b SHALL be registered outputs, with one clk of latency from the phase compare.

Reset
REQ-032 While rst_n = 0, SHALL force state IDLE, phase 0, active and held duty 0, holding register empty.
REQ-033 Output values during reset SHALL be: duty_ready 1, ch_a 0, ch_b 0, period_start 0, underrun 0, busy 0.
REQ-034 Reset asserted mid-period SHALL drop both legs immediately, without waiting for a clock edge.

Structure
REQ-035 The shared package us_pkg SHALL hold PERIOD, HALF, DEAD, DMAX, DUTY_W and the state enum (IDLE, RUN, DRAIN).
REQ-036 SHALL contain one sub-module, us_phase_counter (counter, wrap, phase-0 and terminal-count flags).

Verification
REQ-037 Preload duty 200, enable=1: ch_a high for phases 0-199, ch_b high for phases 337-536, period_start every 675 cycles, no underrun.
REQ-038 Send duty 1000: active duty is 329; ch_a falls at phase 329; ch_b rises at phase 337; both legs are never high together.
REQ-039 Send duty 100, then no further samples: the second period repeats duty 100 and underrun pulses at its phase 0.
REQ-040 Send duty_valid exactly at phase 674 with the holding register full: the old value goes active, the new value is held, duty_ready stays 0 that cycle.
REQ-041 Drop enable at phase 300: the period completes and ch_b still pulses; then IDLE, busy=0, outputs 0.
REQ-042 Assert rst_n=0 at phase 450 while ch_b=1: ch_b=0 with no clock edge; after release, duty_ready=1 and state is IDLE.

Source files
------------

// File: rtl/us_pkg.sv
// ---------------------------------------------------------------------------
// us_pkg
//
// Shared constants and types for the ultrasonic H-bridge driver slice.
//
// Contents:
//   PERIOD  clk cycles per carrier period (40 kHz at 27 MHz)
//   DEAD    minimum clk cycles between one leg falling and the other rising
//   DUTY_W  width of a duty sample
//   HALF    phase at which the negative leg window opens (PERIOD/2, floored)
//   DMAX    largest usable on-time, leaving DEAD cycles before the other leg
//   us_state_t  bridge state (IDLE, RUN, DRAIN)
//   half_of / duty_limit  the same derivations for non-default parameters
// ---------------------------------------------------------------------------
package us_pkg;

    localparam int PERIOD = 675;
    localparam int DEAD   = 8;
    localparam int DUTY_W = 10;
    localparam int HALF   = PERIOD / 2;
    localparam int DMAX   = HALF - DEAD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } us_state_t;

    // Start of the negative-leg window for an arbitrary period length.
    function automatic int half_of(input int period);
        return period / 2;
    endfunction

    // Largest on-time that still leaves the dead band before the other leg.
    function automatic int duty_limit(input int period, input int dead);
        return (period / 2) - dead;
    endfunction

endpackage

// File: rtl/us_phase_counter.sv
// ---------------------------------------------------------------------------
// us_phase_counter
//
// Carrier phase counter. Counts 0..CYCLES-1 and wraps while advance is high;
// is forced back to 0 whenever advance is low.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   advance    count enable (bridge is RUN or DRAIN)
//   phase      current phase, 0..CYCLES-1
//   phase_zero phase == 0
//   terminal   phase == CYCLES-1 (last cycle of the period)
// ---------------------------------------------------------------------------
module us_phase_counter
    import us_pkg::*;
#(
    parameter int CYCLES  = PERIOD,
    parameter int PHASE_W = $clog2(CYCLES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_zero,
    output logic               terminal
);

    assign terminal   = (phase == PHASE_W'(CYCLES - 1));
    assign phase_zero = (phase == '0);

    // Phase register: wraps at the terminal count, and parks at 0 whenever
    // the bridge is idle so the first running cycle is always phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (!advance || terminal) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/us_bridge_driver.sv
// ---------------------------------------------------------------------------
// us_bridge_driver
//
// Two-leg gate driver for an ultrasonic transducer bridge. Each carrier
// period the positive leg is on for the first <duty> cycles and the negative
// leg is on for <duty> cycles starting half a period later. The duty comes
// from a one-deep holding register that is swapped into the active register
// at the end of every period, and is saturated so that the two legs are
// always separated by at least DEAD cycles.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       request bridge operation
//   duty_data    per-period on-time in clk cycles
//   duty_valid   qualifies duty_data
//   duty_ready   holding register is empty
//   ch_a         positive-leg gate drive (registered)
//   ch_b         negative-leg gate drive (registered)
//   period_start one-cycle pulse at phase 0 of each running period
//   underrun     one-cycle pulse when a period starts with no fresh sample
//   busy         bridge is in RUN or DRAIN
// ---------------------------------------------------------------------------
module us_bridge_driver #(
    parameter int PERIOD = us_pkg::PERIOD,
    parameter int DEAD   = us_pkg::DEAD,
    parameter int DUTY_W = us_pkg::DUTY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_data,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              ch_a,
    output logic              ch_b,
    output logic              period_start,
    output logic              underrun,
    output logic              busy
);

    import us_pkg::us_state_t;
    import us_pkg::IDLE;
    import us_pkg::RUN;
    import us_pkg::DRAIN;

    localparam int HALF_PT    = us_pkg::half_of(PERIOD);
    localparam int DUTY_LIMIT = us_pkg::duty_limit(PERIOD, DEAD);
    localparam int PHASE_W    = $clog2(PERIOD);

    us_state_t          state;
    us_state_t          next_state;
    logic [PHASE_W-1:0] phase;
    logic               phase_zero;
    logic               terminal;
    logic               running;
    logic               start_period;
    logic               accept;
    logic [DUTY_W-1:0]  held_duty;
    logic               held_valid;
    logic [DUTY_W-1:0]  active_duty;
    logic [DUTY_W-1:0]  sat_duty;
    logic               underrun_q;
    logic               leg_a_next;
    logic               leg_b_next;
    logic               ch_a_q;
    logic               ch_b_q;
    int                 phase_int;
    int                 duty_int;

    assign running = (state != IDLE);

    us_phase_counter #(
        .CYCLES  (PERIOD),
        .PHASE_W (PHASE_W)
    ) u_phase (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (running),
        .phase      (phase),
        .phase_zero (phase_zero),
        .terminal   (terminal)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A period that is already under way always runs to its
    // last phase; enable only decides, at that last phase, whether another
    // period follows. DRAIN is the "enable has dropped" half of that rule and
    // hops straight back to RUN if enable returns. A new period begins either
    // from IDLE or at the last phase of a period that will be followed by
    // another, and that is the moment the holding register is swapped in.
    always_comb begin
        next_state   = state;
        start_period = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    next_state = terminal ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    next_state = RUN;
                end else if (terminal) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        start_period = (next_state == RUN) && ((state == IDLE) || terminal);
    end

    // A sample can also be taken while the register is full if that same
    // cycle empties it into the active register; duty_ready stays low then.
    assign accept   = duty_valid && (!held_valid || start_period);
    assign sat_duty = (int'(held_duty) > DUTY_LIMIT) ? DUTY_W'(DUTY_LIMIT) : held_duty;

    // Holding / active duty registers. With no fresh sample the previous
    // active duty is reused, except when starting from IDLE, where there is
    // no meaningful previous value and the legs stay off for that period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_duty   <= '0;
            held_valid  <= 1'b0;
            active_duty <= '0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= start_period && !held_valid;
            if (start_period) begin
                if (held_valid) begin
                    active_duty <= sat_duty;
                end else if (state == IDLE) begin
                    active_duty <= '0;
                end
            end
            if (accept) begin
                held_duty  <= duty_data;
                held_valid <= 1'b1;
            end else if (start_period) begin
                held_valid <= 1'b0;
            end
        end
    end

    // Leg windows. Because active_duty never exceeds HALF-DEAD, the positive
    // window ends at least DEAD cycles before the negative one opens, and the
    // negative window ends before the wrap back to phase 0.
    always_comb begin
        phase_int  = int'(phase);
        duty_int   = int'(active_duty);
        leg_a_next = running && (phase_int < duty_int);
        leg_b_next = running && (phase_int >= HALF_PT) && (phase_int < HALF_PT + duty_int);
    end

    // Registered gate drives; the asynchronous reset drops both legs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_a_q <= 1'b0;
            ch_b_q <= 1'b0;
        end else begin
            ch_a_q <= leg_a_next;
            ch_b_q <= leg_b_next;
        end
    end

    assign ch_a         = ch_a_q;
    assign ch_b         = ch_b_q;
    assign duty_ready   = !held_valid;
    assign busy         = running;
    assign period_start = (state == RUN) && phase_zero;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_us_bridge_driver.sv
// ---------------------------------------------------------------------------
// tb_us_bridge_driver
//
// Self-checking bench for us_bridge_driver. A period-level reference model
// (phase, active duty, a one-entry sample queue) predicts every output on
// every cycle; a small vector table covers idle preload and start-up, and
// hand-written sequences cover saturation, underrun, the end-of-period swap,
// draining and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_us_bridge_driver;

    localparam int PERIOD = 675;
    localparam int DEAD   = 8;
    localparam int HALF   = PERIOD / 2;
    localparam int DMAX   = HALF - DEAD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [9:0] duty_data;
    logic       duty_valid;
    logic       duty_ready;
    logic       ch_a;
    logic       ch_b;
    logic       period_start;
    logic       underrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: is a period in progress, where in it, which duty
    // it uses, the pending sample (at most one), and the predicted outputs.
    bit m_on;
    int m_phase;
    int m_duty;
    int m_q[$];
    bit m_under;
    bit m_a;
    bit m_b;

    typedef struct {
        bit         en;
        bit         dv;
        logic [9:0] dd;
        bit         ready;
        bit         busy;
        bit         pstart;
        bit         under;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    us_bridge_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .duty_data    (duty_data),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .ch_a         (ch_a),
        .ch_b         (ch_b),
        .period_start (period_start),
        .underrun     (underrun),
        .busy         (busy)
    );

    task automatic modelReset();
        m_on    = 1'b0;
        m_phase = 0;
        m_duty  = 0;
        m_q.delete();
        m_under = 1'b0;
        m_a     = 1'b0;
        m_b     = 1'b0;
    endtask

    // One clock of behaviour, from the state before the edge and the inputs
    // held across it. A period keeps going to its last phase; another one
    // follows only if enable is high at that last phase.
    task automatic modelStep(input bit en, input bit dv, input int dd);
        bit last;
        bit start;
        bit take;
        last  = m_on && (m_phase == PERIOD - 1);
        start = (!m_on && en) || (last && en);
        take  = dv && ((m_q.size() == 0) || start);
        m_a   = m_on && (m_phase < m_duty);
        m_b   = m_on && (m_phase >= HALF) && (m_phase < HALF + m_duty);
        m_under = 1'b0;
        if (start) begin
            if (m_q.size() > 0) begin
                m_duty = (m_q[0] > DMAX) ? DMAX : m_q[0];
                void'(m_q.pop_front());
            end else begin
                m_under = 1'b1;
                if (!m_on) m_duty = 0;
            end
        end
        if (take) m_q.push_back(dd);
        if (m_on) m_phase = last ? 0 : m_phase + 1;
        if (start) m_on = 1'b1;
        else if (last) m_on = 1'b0;
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [5:0] got;
        logic [5:0] want;
        got  = {duty_ready, ch_a, ch_b, period_start, underrun, busy};
        want = {(m_q.size() == 0), m_a, m_b, (m_on && m_phase == 0), m_under, m_on};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s {ready,a,b,pstart,under,busy}: got %b, want %b (phase %0d, t=%0t)",
                     name, got, want, m_phase, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and check all outputs
    // one time unit after the rising edge.
    task automatic applyStimulus(input bit en, input bit dv, input logic [9:0] dd);
        enable     = en;
        duty_valid = dv;
        duty_data  = dd;
        modelStep(en, dv, int'(dd));
        @(posedge clk);
        #1;
        checkOutput("cycle");
    endtask

    task automatic runToPhase(input int target, input bit en, input bit dv, input logic [9:0] dd);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 2; i++) begin
            applyStimulus(en, dv, dd);
            if (m_on && m_phase == target) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            total++;
            bad++;
            $display("[TB] FAIL runToPhase %0d: bound expired, got no match, want phase reached", target);
        end
    endtask

    // Apply one full period starting from a phase-0 cycle. Observation i
    // shows the leg compare for phase i-1; the final observation is the
    // following phase 0, so its period_start/underrun belong to the next period.
    task automatic runPeriod(input bit en, input bit dv, input logic [9:0] dd,
                             output int na, output int nb, output int nps, output int nun,
                             output int nov, output int last_a, output int first_b);
        na = 0; nb = 0; nps = 0; nun = 0; nov = 0; last_a = -1; first_b = -1;
        for (int i = 1; i <= PERIOD; i++) begin
            applyStimulus(en, dv, dd);
            if (ch_a) begin na++; last_a = i - 1; end
            if (ch_b) begin nb++; if (first_b < 0) first_b = i - 1; end
            if (period_start) nps++;
            if (underrun) nun++;
            if (ch_a && ch_b) nov++;
        end
    endtask

    initial begin
        int  na, nb, nps, nun, nov, last_a, first_b;
        bit  en_r;
        bit  drained;

        tbl[0] = '{en: 1'b0, dv: 1'b0, dd: 10'd0,   ready: 1'b1, busy: 1'b0, pstart: 1'b0, under: 1'b0};
        tbl[1] = '{en: 1'b0, dv: 1'b1, dd: 10'd200, ready: 1'b0, busy: 1'b0, pstart: 1'b0, under: 1'b0};
        tbl[2] = '{en: 1'b0, dv: 1'b1, dd: 10'd50,  ready: 1'b0, busy: 1'b0, pstart: 1'b0, under: 1'b0};
        tbl[3] = '{en: 1'b1, dv: 1'b0, dd: 10'd0,   ready: 1'b1, busy: 1'b1, pstart: 1'b1, under: 1'b0};
        tbl[4] = '{en: 1'b1, dv: 1'b1, dd: 10'd200, ready: 1'b0, busy: 1'b1, pstart: 1'b0, under: 1'b0};
        tbl[5] = '{en: 1'b1, dv: 1'b0, dd: 10'd0,   ready: 1'b0, busy: 1'b1, pstart: 1'b0, under: 1'b0};

        rst_n      = 1'b1;
        enable     = 1'b0;
        duty_valid = 1'b0;
        duty_data  = '0;
        #1;
        rst_n = 1'b0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;

        // Idle preload, rejected second sample, start-up using the preload.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].en, tbl[i].dv, tbl[i].dd);
            checkValue($sformatf("vec%0d ready", i), int'(duty_ready), int'(tbl[i].ready));
            checkValue($sformatf("vec%0d busy", i), int'(busy), int'(tbl[i].busy));
            checkValue($sformatf("vec%0d period_start", i), int'(period_start), int'(tbl[i].pstart));
            checkValue($sformatf("vec%0d underrun", i), int'(underrun), int'(tbl[i].under));
        end

        // Steady duty 200, samples always on offer.
        runToPhase(0, 1'b1, 1'b1, 10'd200);
        runPeriod(1'b1, 1'b1, 10'd200, na, nb, nps, nun, nov, last_a, first_b);
        checkValue("d200 ch_a cycles", na, 200);
        checkValue("d200 ch_b cycles", nb, 200);
        checkValue("d200 ch_b first phase", first_b, HALF);
        checkValue("d200 period_start", nps, 1);
        checkValue("d200 underrun", nun, 0);

        // Oversized sample saturates to DMAX.
        runToPhase(0, 1'b1, 1'b0, 10'd0);
        applyStimulus(1'b1, 1'b1, 10'd1000);
        runToPhase(0, 1'b1, 1'b0, 10'd0);
        runPeriod(1'b1, 1'b0, 10'd0, na, nb, nps, nun, nov, last_a, first_b);
        checkValue("sat ch_a cycles", na, DMAX);
        checkValue("sat ch_a last phase", last_a, DMAX - 1);
        checkValue("sat ch_b first phase", first_b, HALF);
        checkValue("sat overlap", nov, 0);
        checkValue("sat underrun next", nun, 1);

        // Single sample then starvation: duty is reused and underrun flags it.
        applyStimulus(1'b1, 1'b1, 10'd100);
        runToPhase(0, 1'b1, 1'b0, 10'd0);
        runPeriod(1'b1, 1'b0, 10'd0, na, nb, nps, nun, nov, last_a, first_b);
        checkValue("d100 first ch_a", na, 100);
        checkValue("d100 underrun at 2nd start", nun, 1);
        runPeriod(1'b1, 1'b0, 10'd0, na, nb, nps, nun, nov, last_a, first_b);
        checkValue("d100 repeat ch_a", na, 100);

        // New sample exactly at the last phase while the register is full.
        applyStimulus(1'b1, 1'b1, 10'd150);
        runToPhase(PERIOD - 1, 1'b1, 1'b0, 10'd0);
        checkValue("swap ready at last phase", int'(duty_ready), 0);
        applyStimulus(1'b1, 1'b1, 10'd250);
        checkValue("swap ready after", int'(duty_ready), 0);
        runPeriod(1'b1, 1'b0, 10'd0, na, nb, nps, nun, nov, last_a, first_b);
        checkValue("swap old value active", na, 150);
        checkValue("swap no underrun", nun, 0);
        runPeriod(1'b1, 1'b0, 10'd0, na, nb, nps, nun, nov, last_a, first_b);
        checkValue("swap new value active", na, 250);

        // Drop enable mid-period: the period completes, then idle.
        runToPhase(300, 1'b1, 1'b0, 10'd0);
        nb = 0;
        drained = 1'b0;
        for (int i = 0; i < PERIOD + 5; i++) begin
            applyStimulus(1'b0, 1'b0, 10'd0);
            if (ch_b) nb++;
            if (!m_on) begin
                drained = 1'b1;
                break;
            end
        end
        checkValue("drain ch_b cycles", nb, 250);
        checkValue("drain reached idle", int'(drained), 1);
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkValue("drain busy", int'(busy), 0);
        checkValue("drain legs", int'({ch_a, ch_b}), 0);

        // Asynchronous reset while the negative leg is on.
        applyStimulus(1'b0, 1'b1, 10'd200);
        applyStimulus(1'b1, 1'b0, 10'd0);
        runToPhase(450, 1'b1, 1'b0, 10'd0);
        checkValue("pre-reset ch_b", int'(ch_b), 1);
        rst_n = 1'b0;
        #2;
        checkValue("async reset ch_b", int'(ch_b), 0);
        checkValue("async reset ch_a", int'(ch_a), 0);
        checkValue("async reset busy", int'(busy), 0);
        checkValue("async reset ready", int'(duty_ready), 1);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 10'd0);
        checkValue("post-reset ready", int'(duty_ready), 1);
        checkValue("post-reset busy", int'(busy), 0);

        // Randomised traffic, every cycle checked against the model.
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) en_r = ~en_r;
            applyStimulus(en_r, ($urandom_range(0, 3) == 0), 10'($urandom_range(0, 1023)));
            if (ch_a && ch_b) checkValue("random overlap", 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
